// File: rtl/m_pcpi_frontend.sv
// ---------------------------------------------------------------------------
// m_pcpi_frontend
// PCPI front-end that claims RV32M and custom-0 instructions from the CPU.
// It forwards a latched copy of each claimed request to an M/custom
// coprocessor and returns the coprocessor's result to the CPU as a
// one-cycle PCPI response.
//
// Optional feature: define PCPI_TIMEOUT_EN to bound the WAIT state.
// After TIMEOUT_CYCLES WAIT cycles without cop_ready, the request is
// answered with pcpi_wr=0 / pcpi_rd=0 and the sticky timeout_err is raised.
// Without the macro, WAIT is unbounded and timeout_err is tied to 0.
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   reset        in   synchronous, active-high reset
//   pcpi_valid   in   CPU request valid (held until pcpi_ready)
//   pcpi_insn    in   CPU instruction word [31:0]
//   pcpi_rs1/2   in   CPU operands [31:0]
//   pcpi_wr      out  result writeback enable (valid with pcpi_ready)
//   pcpi_rd      out  result data [31:0], zero unless pcpi_ready
//   pcpi_wait    out  request claimed and in progress
//   pcpi_ready   out  one-cycle request-complete strobe
//   cop_valid    out  one-cycle start pulse to the coprocessor
//   cop_insn     out  latched instruction [31:0]
//   cop_rs1/2    out  latched operands [31:0]
//   cop_ready    in   coprocessor done
//   cop_wr       in   coprocessor writeback flag
//   cop_result   in   coprocessor result [31:0]
//   timeout_err  out  sticky abort flag (cleared only by reset)
// ---------------------------------------------------------------------------
module m_pcpi_frontend #(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        cop_valid,
  output logic [31:0] cop_insn,
  output logic [31:0] cop_rs1,
  output logic [31:0] cop_rs2,
  input  logic        cop_ready,
  input  logic        cop_wr,
  input  logic [31:0] cop_result,
  output logic        timeout_err
);

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_CUST0  = 7'b0001011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  localparam logic [6:0] F7_CUST0   = 7'b0000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } state_e;

  state_e            state_q;

  logic              cop_valid_q;
  logic [XLEN-1:0]   cop_insn_q;
  logic [XLEN-1:0]   cop_rs1_q;
  logic [XLEN-1:0]   cop_rs2_q;

  logic              pcpi_wait_q;
  logic              pcpi_ready_q;
  logic              pcpi_wr_q;
  logic [XLEN-1:0]   pcpi_rd_q;

  logic              claim_c;

  // Instruction decode: RV32M (OP + funct7=0000001) or custom-0 (funct7=0).
  always_comb begin
    claim_c = 1'b0;
    if ((pcpi_insn[6:0] == OPC_OP) && (pcpi_insn[31:25] == F7_MULDIV)) begin
      claim_c = 1'b1;
    end
    if ((pcpi_insn[6:0] == OPC_CUST0) && (pcpi_insn[31:25] == F7_CUST0)) begin
      claim_c = 1'b1;
    end
  end

`ifdef PCPI_TIMEOUT_EN
  // Counter wide enough to hold TIMEOUT_CYCLES itself.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              timeout_err_q;
  logic              expire_c;

  // Count of WAIT cycles including the current one; expiry when it hits the limit.
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    expire_c = (cnt_d == CNT_W'(TIMEOUT_CYCLES));
  end
`else
  logic              unused_timeout_cycles;
  assign unused_timeout_cycles = ^XLEN'(TIMEOUT_CYCLES);
`endif

  // Request sequencer; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cop_valid_q   <= 1'b0;
      cop_insn_q    <= '0;
      cop_rs1_q     <= '0;
      cop_rs2_q     <= '0;
      pcpi_wait_q   <= 1'b0;
      pcpi_ready_q  <= 1'b0;
      pcpi_wr_q     <= 1'b0;
      pcpi_rd_q     <= '0;
`ifdef PCPI_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      // Single-cycle strobes default low; pcpi_rd is zero outside RESP.
      cop_valid_q  <= 1'b0;
      pcpi_ready_q <= 1'b0;
      pcpi_wr_q    <= 1'b0;
      pcpi_rd_q    <= '0;

      case (state_q)
        ST_IDLE: begin
          if (pcpi_valid && claim_c) begin
            state_q     <= ST_ISSUE;
            cop_insn_q  <= pcpi_insn;
            cop_rs1_q   <= pcpi_rs1;
            cop_rs2_q   <= pcpi_rs2;
            cop_valid_q <= 1'b1;
            pcpi_wait_q <= 1'b1;
          end
        end

        ST_ISSUE: begin
          // A coprocessor may answer in the same cycle it is started.
          if (cop_ready) begin
            state_q      <= ST_RESP;
            pcpi_wait_q  <= 1'b0;
            pcpi_ready_q <= 1'b1;
            pcpi_wr_q    <= cop_wr;
            pcpi_rd_q    <= cop_result;
          end else begin
            state_q <= ST_WAIT;
`ifdef PCPI_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end

        ST_WAIT: begin
          // cop_ready takes priority over a simultaneous expiry.
          if (cop_ready) begin
            state_q      <= ST_RESP;
            pcpi_wait_q  <= 1'b0;
            pcpi_ready_q <= 1'b1;
            pcpi_wr_q    <= cop_wr;
            pcpi_rd_q    <= cop_result;
          end
`ifdef PCPI_TIMEOUT_EN
          else if (expire_c) begin
            state_q       <= ST_RESP;
            pcpi_wait_q   <= 1'b0;
            pcpi_ready_q  <= 1'b1;
            timeout_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
`endif
        end

        ST_RESP: begin
          state_q <= ST_DRAIN;
        end

        // Hold off until the CPU releases the request so it is not claimed again.
        ST_DRAIN: begin
          if (!pcpi_valid) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cop_valid  = cop_valid_q;
  assign cop_insn   = cop_insn_q;
  assign cop_rs1    = cop_rs1_q;
  assign cop_rs2    = cop_rs2_q;
  assign pcpi_wait  = pcpi_wait_q;
  assign pcpi_ready = pcpi_ready_q;
  assign pcpi_wr    = pcpi_wr_q;
  assign pcpi_rd    = pcpi_rd_q;

`ifdef PCPI_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_m_pcpi_frontend.sv
// ---------------------------------------------------------------------------
// tb_m_pcpi_frontend
// Directed and randomized transactions against m_pcpi_frontend. Expected
// outputs come from a transaction-level timeline: a claimed request shows
// cop_valid in its first busy cycle, pcpi_wait for every busy cycle, then a
// single response cycle, then quiet outputs while the CPU still holds valid.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_m_pcpi_frontend;

  localparam int unsigned TO = 63;

  logic        clk;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        cop_valid;
  logic [31:0] cop_insn;
  logic [31:0] cop_rs1;
  logic [31:0] cop_rs2;
  logic        cop_ready;
  logic        cop_wr;
  logic [31:0] cop_result;
  logic        timeout_err;

  int checks;
  int errors;

  // Model state: last claimed request and the sticky abort flag.
  logic [31:0] exp_ci;
  logic [31:0] exp_c1;
  logic [31:0] exp_c2;
  logic        exp_err;

  m_pcpi_frontend #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_rs1    (pcpi_rs1),
    .pcpi_rs2    (pcpi_rs2),
    .pcpi_wr     (pcpi_wr),
    .pcpi_rd     (pcpi_rd),
    .pcpi_wait   (pcpi_wait),
    .pcpi_ready  (pcpi_ready),
    .cop_valid   (cop_valid),
    .cop_insn    (cop_insn),
    .cop_rs1     (cop_rs1),
    .cop_rs2     (cop_rs2),
    .cop_ready   (cop_ready),
    .cop_wr      (cop_wr),
    .cop_result  (cop_result),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cycle(input string ph, input logic cv, input logic wt, input logic rdy,
                           input logic wr, input logic [31:0] rd);
    chk({ph, "/cop_valid"},   32'(cop_valid),   32'(cv));
    chk({ph, "/pcpi_wait"},   32'(pcpi_wait),   32'(wt));
    chk({ph, "/pcpi_ready"},  32'(pcpi_ready),  32'(rdy));
    chk({ph, "/pcpi_wr"},     32'(pcpi_wr),     32'(wr));
    chk({ph, "/pcpi_rd"},     pcpi_rd,          rd);
    chk({ph, "/cop_insn"},    cop_insn,         exp_ci);
    chk({ph, "/cop_rs1"},     cop_rs1,          exp_c1);
    chk({ph, "/cop_rs2"},     cop_rs2,          exp_c2);
    chk({ph, "/timeout_err"}, 32'(timeout_err), 32'(exp_err));
  endtask

  function automatic logic claims(input logic [31:0] insn);
    return ((insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001)) ||
           ((insn[6:0] == 7'b0001011) && (insn[31:25] == 7'b0000000));
  endfunction

  function automatic logic [31:0] rand_insn(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0: begin r[31:25] = 7'b0000001; r[6:0] = 7'b0110011; end
      1: begin r[31:25] = 7'b0000000; r[6:0] = 7'b0001011; end
      2: begin r[31:25] = 7'b0000000; r[6:0] = 7'b0110011; end
      3: begin r[31:25] = 7'b0000001; r[6:0] = 7'b0001011; end
      default: ;
    endcase
    return r;
  endfunction

  // One CPU transaction. d: busy-cycle index at which cop_ready is given
  // (0 = in the start cycle), or the cycle count for an unclaimed request.
  // hold: extra cycles the CPU keeps valid after the response.
  // drop: CPU drops valid while the operation is in flight.
  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                         input int d, input logic [31:0] res, input logic w,
                         input int hold, input bit drop);
    int resp_k;
    bit to;
    @(negedge clk);
    chk_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
    cop_ready  = 1'($urandom);
    cop_result = $urandom;
    cop_wr     = 1'($urandom);
    if (!claims(insn)) begin
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        chk_cycle("noclaim", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cop_ready = 1'($urandom);
      end
      pcpi_valid = 1'b0;
      cop_ready  = 1'b0;
      return;
    end
    exp_ci = insn;
    exp_c1 = rs1;
    exp_c2 = rs2;
    resp_k = d + 1;
    to     = 1'b0;
`ifdef PCPI_TIMEOUT_EN
    if (d > int'(TO)) begin
      resp_k = int'(TO) + 1;
      to     = 1'b1;
    end
`endif
    for (int k = 0; k < resp_k; k++) begin
      @(negedge clk);
      chk_cycle("busy", (k == 0), 1'b1, 1'b0, 1'b0, 32'h0);
      cop_ready  = (k == d);
      cop_result = (k == d) ? res : $urandom;
      cop_wr     = (k == d) ? w : 1'($urandom);
      pcpi_insn  = $urandom;
      pcpi_rs1   = $urandom;
      pcpi_rs2   = $urandom;
      if (drop) pcpi_valid = 1'b0;
    end
    @(negedge clk);
    if (to) exp_err = 1'b1;
    chk_cycle("resp", 1'b0, 1'b0, 1'b1, to ? 1'b0 : w, to ? 32'h0 : res);
    // Keep a claimable request on the bus so any premature re-claim shows up.
    pcpi_insn  = insn;
    cop_ready  = 1'($urandom);
    cop_result = $urandom;
    pcpi_valid = drop ? 1'b0 : (hold > 0);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk_cycle("drain", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      cop_ready  = 1'($urandom);
      pcpi_valid = drop ? 1'b0 : (i + 1 < hold);
    end
    cop_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    exp_ci     = '0;
    exp_c1     = '0;
    exp_c2     = '0;
    exp_err    = 1'b0;
    reset      = 1'b1;
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h02B50533;
    pcpi_rs1   = 32'h1;
    pcpi_rs2   = 32'h2;
    cop_ready  = 1'b1;
    cop_wr     = 1'b1;
    cop_result = 32'hFFFF_FFFF;

    // Reset state, even with a claimable request and cop_ready present.
    @(posedge clk);
    @(negedge clk);
    chk_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk_cycle("reset2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset      = 1'b0;
    pcpi_valid = 1'b0;
    cop_ready  = 1'b0;

    // MUL 7*6 with cop_ready three cycles after start.
    run_txn(32'h02B50533, 32'd7, 32'd6, 3, 32'd42, 1'b1, 0, 1'b0);
    // ADD is not claimed even with valid held for 10 cycles.
    run_txn(32'h00B50533, 32'd1, 32'd2, 10, 32'd0, 1'b0, 0, 1'b0);
    // Valid held 4 cycles after the response: no second claim.
    run_txn(32'h02C5C5B3, 32'h1234, 32'h5678, 1, 32'hCAFE_F00D, 1'b1, 4, 1'b0);
    // New claim right after valid drops.
    run_txn(32'h02B50533, 32'd3, 32'd5, 2, 32'd15, 1'b1, 0, 1'b0);
    // Custom-0 answered in the start cycle with no writeback.
    run_txn(32'h00C5850B, 32'hAAAA_0000, 32'h0000_5555, 0, 32'h600D_D00D, 1'b0, 0, 1'b0);
    // Valid dropped mid-operation: response still issued.
    run_txn(32'h02B50533, 32'd9, 32'd9, 4, 32'd81, 1'b1, 0, 1'b1);

    // Reset two cycles into WAIT; the late cop_ready must be ignored.
    @(negedge clk);
    chk_cycle("pre_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h02B50533;
    pcpi_rs1   = 32'd11;
    pcpi_rs2   = 32'd13;
    exp_ci     = 32'h02B50533;
    exp_c1     = 32'd11;
    exp_c2     = 32'd13;
    @(negedge clk);
    chk_cycle("rst_issue", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_cycle("rst_wait", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    reset = 1'b1;
    @(negedge clk);
    exp_ci  = '0;
    exp_c1  = '0;
    exp_c2  = '0;
    exp_err = 1'b0;
    chk_cycle("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset      = 1'b0;
    pcpi_valid = 1'b0;
    cop_ready  = 1'b1;
    cop_wr     = 1'b1;
    cop_result = 32'd143;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_cycle("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    cop_ready = 1'b0;

`ifdef PCPI_TIMEOUT_EN
    // cop_ready on the expiry cycle wins; no abort flag.
    run_txn(32'h02B50533, 32'd2, 32'd2, int'(TO), 32'd4, 1'b1, 0, 1'b0);
    // Coprocessor never answers: aborted response, sticky flag.
    run_txn(32'h02B50533, 32'd8, 32'd8, 1000, 32'd0, 1'b1, 1, 1'b0);
    run_txn(32'h00C5850B, 32'd1, 32'd1, 2, 32'h77, 1'b1, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    exp_ci  = '0;
    exp_c1  = '0;
    exp_c2  = '0;
    exp_err = 1'b0;
    chk_cycle("to_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
`endif

    // Randomized mix of claimed, unclaimed, held and dropped requests.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] ins;
      ins = rand_insn($urandom_range(0, 4));
      run_txn(ins, $urandom, $urandom, $urandom_range(0, 5), $urandom, 1'($urandom),
              $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end

    @(negedge clk);
    chk_cycle("final", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
